// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath widths, reset vector and the fetch-to-decode packet type.
package cpu_pkg;

    localparam int DATA_W    = 32;
    localparam int PC_W      = 32;
    localparam int IM_ADDR_W = 10;

    localparam logic [PC_W-1:0]   RESET_PC = 32'h0000_0000;
    localparam logic [DATA_W-1:0] NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [DATA_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic              valid;
    } fetch_pkt_t;

endpackage

// File: rtl/if_fetch_unit_skid_buf.sv
// Single-entry hold register that parks a returned instruction while decode is stalled.
module if_skid_buf
    import cpu_pkg::*;
#(
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              consume,
    input  logic              flush,
    input  logic [INST_W-1:0] cap_inst,
    input  logic [PC_W-1:0]   cap_pc,
    output logic              hold_valid,
    output logic [INST_W-1:0] hold_inst,
    output logic [PC_W-1:0]   hold_pc
);

    // Flush wins over capture, capture over consume; capture is only ever
    // requested while empty, so at most one entry exists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_inst  <= INST_W'(NOP_INST);
            hold_pc    <= '0;
        end else if (flush) begin
            hold_valid <= 1'b0;
        end else if (capture) begin
            hold_valid <= 1'b1;
            hold_inst  <= cap_inst;
            hold_pc    <= cap_pc;
        end else if (consume) begin
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the 1-cycle-latency instruction
// memory read port, and presents {if_inst, if_pc, if_valid} to decode.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter int          IM_ADDR_W = cpu_pkg::IM_ADDR_W,
    parameter int          DATA_W    = cpu_pkg::DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    input  logic [DATA_W-1:0]    IM_out,
    output logic                 IM_read,
    output logic [IM_ADDR_W-1:0] IM_addr,
    output logic [DATA_W-1:0]    if_inst,
    output logic [31:0]          if_pc,
    output logic                 if_valid
);

    localparam int PC_W = cpu_pkg::PC_W;

    logic [PC_W-1:0]   fetch_pc;
    logic              resp_valid;
    logic [PC_W-1:0]   resp_pc;

    logic [PC_W-1:0]   issue_pc;
    logic              issue;
    logic [PC_W-1:0]   fetch_pc_nxt;
    logic [PC_W-1:0]   resp_pc_nxt;

    logic              hold_valid;
    logic [DATA_W-1:0] hold_inst;
    logic [PC_W-1:0]   hold_pc;
    logic              hold_capture;
    logic              hold_consume;

    // A redirect always issues its target; otherwise issue only when decode
    // can take data and nothing is parked in the hold register.
    always_comb begin
        issue        = 1'b0;
        issue_pc     = fetch_pc;
        fetch_pc_nxt = fetch_pc;
        resp_pc_nxt  = resp_pc;
        if (!rst) begin
            if (redirect) begin
                issue        = 1'b1;
                issue_pc     = redirect_pc;
                fetch_pc_nxt = redirect_pc + 32'd4;
                resp_pc_nxt  = redirect_pc;
            end else if (!id_stall && !hold_valid) begin
                issue        = 1'b1;
                fetch_pc_nxt = fetch_pc + 32'd4;
                resp_pc_nxt  = fetch_pc;
            end
        end
    end

    assign IM_read = issue;
    assign IM_addr = issue_pc[IM_ADDR_W+1:2];

    logic unused_issue_bits;
    assign unused_issue_bits = ^{issue_pc[1:0], issue_pc[PC_W-1:IM_ADDR_W+2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            resp_valid <= 1'b0;
            resp_pc    <= RESET_PC;
        end else begin
            fetch_pc   <= fetch_pc_nxt;
            resp_valid <= issue;
            resp_pc    <= resp_pc_nxt;
        end
    end

    // Decode handshake: a word transfers in any cycle with if_valid=1 and
    // id_stall=0; if_inst/if_pc stay stable while if_valid=1 and id_stall=1.
    assign hold_capture = resp_valid && id_stall && !hold_valid && !redirect;
    assign hold_consume = hold_valid && !id_stall;

    if_skid_buf #(
        .INST_W (DATA_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .capture    (hold_capture),
        .consume    (hold_consume),
        .flush      (redirect),
        .cap_inst   (IM_out),
        .cap_pc     (resp_pc),
        .hold_valid (hold_valid),
        .hold_inst  (hold_inst),
        .hold_pc    (hold_pc)
    );

    assign if_valid = (hold_valid | resp_valid) & ~redirect & ~rst;

    always_comb begin
        if_inst = DATA_W'(cpu_pkg::NOP_INST);
        if_pc   = resp_pc;
        if (hold_valid) begin
            if_inst = hold_inst;
            if_pc   = hold_pc;
        end else if (!rst) begin
            if_inst = IM_out;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: per-cycle vector table plus an in-order delivery scoreboard.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] IM_out = '0;
    logic        IM_read;
    logic [9:0]  IM_addr;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_valid;

    logic [31:0] mem [0:1023];

    int n_vec = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        read;
        logic [9:0]  addr;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
    } vec_t;

    vec_t vt[26];

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .id_stall    (id_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .IM_out      (IM_out),
        .IM_read     (IM_read),
        .IM_addr     (IM_addr),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_valid    (if_valid)
    );

    // Instruction memory: fixed 1-cycle read latency, zero when not read.
    always @(posedge clk) IM_out <= IM_read ? mem[IM_addr] : 32'h0;

    function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [31:0] rp,
                                input logic rd, input logic [9:0] a, input logic v,
                                input logic [31:0] in, input logic [31:0] p);
        vec_t t;
        t.rst = r; t.stall = s; t.redir = d; t.rpc = rp;
        t.read = rd; t.addr = a; t.valid = v; t.inst = in; t.pc = p;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_consume(input int idx);
        logic [63:0] e;
        if (if_valid && !id_stall) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL consume[%0d]: unexpected pc %h inst %h, expected none", idx, if_pc, if_inst);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("consume_pc[%0d]", idx), if_pc, e[63:32]);
                check($sformatf("consume_inst[%0d]", idx), if_inst, e[31:0]);
            end
        end
    endtask

    initial begin
        int budget;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + i;

        //            rst stl rdr rpc           read addr    vld inst          pc
        vt[0]  = mk(1, 0, 0, 32'h0,     0, 10'h000, 0, 32'h0,     32'h0);
        vt[1]  = mk(1, 0, 0, 32'h0,     0, 10'h000, 0, 32'h0,     32'h0);
        vt[2]  = mk(0, 0, 0, 32'h0,     1, 10'h000, 0, 32'h0,     32'h0);
        vt[3]  = mk(0, 0, 0, 32'h0,     1, 10'h001, 1, 32'h1000,  32'h0);
        vt[4]  = mk(0, 0, 0, 32'h0,     1, 10'h002, 1, 32'h1001,  32'h4);
        vt[5]  = mk(0, 1, 0, 32'h0,     0, 10'h003, 1, 32'h1002,  32'h8);
        vt[6]  = mk(0, 1, 0, 32'h0,     0, 10'h003, 1, 32'h1002,  32'h8);
        vt[7]  = mk(0, 1, 0, 32'h0,     0, 10'h003, 1, 32'h1002,  32'h8);
        vt[8]  = mk(0, 0, 0, 32'h0,     0, 10'h003, 1, 32'h1002,  32'h8);
        vt[9]  = mk(0, 0, 0, 32'h0,     1, 10'h003, 0, 32'h0,     32'h0);
        vt[10] = mk(0, 0, 1, 32'h40,    1, 10'h010, 0, 32'h0,     32'h0);
        vt[11] = mk(0, 0, 0, 32'h0,     1, 10'h011, 1, 32'h1010,  32'h40);
        vt[12] = mk(0, 1, 0, 32'h0,     0, 10'h012, 1, 32'h1011,  32'h44);
        vt[13] = mk(0, 1, 1, 32'h80,    1, 10'h020, 0, 32'h0,     32'h0);
        vt[14] = mk(0, 1, 0, 32'h0,     0, 10'h021, 1, 32'h1020,  32'h80);
        vt[15] = mk(0, 1, 0, 32'h0,     0, 10'h021, 1, 32'h1020,  32'h80);
        vt[16] = mk(0, 0, 0, 32'h0,     0, 10'h021, 1, 32'h1020,  32'h80);
        vt[17] = mk(0, 0, 1, 32'hFFC,   1, 10'h3FF, 0, 32'h0,     32'h0);
        vt[18] = mk(0, 0, 0, 32'h0,     1, 10'h000, 1, 32'h13FF,  32'hFFC);
        vt[19] = mk(0, 0, 1, 32'h42,    1, 10'h010, 0, 32'h0,     32'h0);
        vt[20] = mk(0, 0, 0, 32'h0,     1, 10'h011, 1, 32'h1010,  32'h42);
        vt[21] = mk(0, 1, 0, 32'h0,     0, 10'h012, 1, 32'h1011,  32'h46);
        vt[22] = mk(1, 1, 0, 32'h0,     0, 10'h000, 0, 32'h0,     32'h0);
        vt[23] = mk(0, 0, 0, 32'h0,     1, 10'h000, 0, 32'h0,     32'h0);
        vt[24] = mk(0, 0, 0, 32'h0,     1, 10'h001, 1, 32'h1000,  32'h0);
        vt[25] = mk(0, 0, 0, 32'h0,     1, 10'h002, 1, 32'h1001,  32'h4);

        // Instructions decode should accept across the table, in order.
        exp_q.push_back({32'h0,   32'h1000});
        exp_q.push_back({32'h4,   32'h1001});
        exp_q.push_back({32'h8,   32'h1002});
        exp_q.push_back({32'h40,  32'h1010});
        exp_q.push_back({32'h80,  32'h1020});
        exp_q.push_back({32'hFFC, 32'h13FF});
        exp_q.push_back({32'h42,  32'h1010});
        exp_q.push_back({32'h0,   32'h1000});
        exp_q.push_back({32'h4,   32'h1001});

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            rst         = vt[i].rst;
            id_stall    = vt[i].stall;
            redirect    = vt[i].redir;
            redirect_pc = vt[i].rpc;
            #1;
            check($sformatf("IM_read[%0d]", i), {31'h0, IM_read}, {31'h0, vt[i].read});
            check($sformatf("IM_addr[%0d]", i), {22'h0, IM_addr}, {22'h0, vt[i].addr});
            check($sformatf("if_valid[%0d]", i), {31'h0, if_valid}, {31'h0, vt[i].valid});
            if (vt[i].valid || vt[i].rst) begin
                check($sformatf("if_inst[%0d]", i), if_inst, vt[i].inst);
                check($sformatf("if_pc[%0d]", i), if_pc, vt[i].pc);
            end
            check_consume(i);
        end
        check("table_drained", exp_q.size(), 0);

        // Free run with random stalls: sequential delivery resumes from pc 8.
        for (int k = 0; k < 40; k++) begin
            logic [31:0] p;
            p = 32'h8 + 32'(4 * k);
            exp_q.push_back({p, 32'h1000 + {22'h0, p[11:2]}});
        end
        budget = 0;
        while (exp_q.size() > 0 && budget < 400) begin
            @(negedge clk);
            rst      = 1'b0;
            redirect = 1'b0;
            id_stall = ($urandom_range(0, 3) == 0);
            #1;
            check_consume(100 + budget);
            budget++;
        end
        check("random_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
